// File: rtl/wptr_full.sv
// Write-side pointer, full flag, fill level and sticky overflow for the async FIFO (wclk domain).
// Define WPTR_ALMOST_FULL_EN to build the almost-full compare; otherwise walmost_full is tied low.
module wptr_full #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf,
    output logic                walmost_full
);
    localparam int unsigned   PW      = ADDRSIZE + 1;
    localparam int unsigned   DEPTH   = 1 << ADDRSIZE;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    if (ADDRSIZE < 2) begin : g_bad_addrsize
        $error("wptr_full: ADDRSIZE must be >= 2");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN >= DEPTH) begin : g_bad_margin
        $error("wptr_full: AFULL_MARGIN must be in 1..2**ADDRSIZE-1");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          wpush;
    logic          wfull_next;
    logic          wovf_next;

    assign waddr = wbin[ADDRSIZE-1:0];

    // Next pointers, synchronized read pointer in binary, and next flags
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
        wpush      = winc & ~wfull;
        wbinnext   = wbin + PW'(wpush);
        wgraynext  = (wbinnext >> 1) ^ wbinnext;
        wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        level_next = wbinnext - rbin;
        wovf_next  = wovf;
        if (winc && wfull) begin
            wovf_next = 1'b1;
        end else if (wovf_clr) begin
            wovf_next = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wlevel <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= wfull_next;
            wlevel <= level_next;
            wovf   <= wovf_next;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    logic [PW-1:0] free_next;
    logic          walmost_next;

    // Free slots after this edge; a full FIFO always reads as almost full
    always_comb begin
        free_next    = DEPTH_P - level_next;
        walmost_next = (free_next <= PW'(AFULL_MARGIN)) | wfull_next;
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            walmost_full <= 1'b0;
        end else begin
            walmost_full <= walmost_next;
        end
    end
`else
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: integer write/read-count model checked every cycle, plus literal spot checks.
module tb_wptr_full;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    logic          wclk = 1'b0;
    logic          rst_n;
    logic          winc;
    logic [PW-1:0] wq2_rptr;
    logic          wovf_clr;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic [PW-1:0] wlevel;
    logic          wovf;
    logic          walmost_full;

    int total = 0;
    int bad   = 0;

    // Model state: counts of accepted writes and of reads visible to the write side
    int  m_wr     = 0;
    int  rd_cnt   = 0;
    int  m_level  = 0;
    bit  m_full   = 1'b0;
    bit  m_ovf    = 1'b0;
    bit  check_en = 1'b0;
    logic [PW-1:0] prev_wptr = '0;

    wptr_full #(.ADDRSIZE(AW), .AFULL_MARGIN(2)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .wovf_clr    (wovf_clr),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .wlevel      (wlevel),
        .wovf        (wovf),
        .walmost_full(walmost_full)
    );

    always #5 wclk = ~wclk;

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic bit exp_almost(input int level);
`ifdef WPTR_ALMOST_FULL_EN
        return (16 - level) <= 2;
`else
        return (level < 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr    = 0;
            m_level = 0;
            m_full  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (winc && m_full) m_ovf = 1'b1;
            else if (wovf_clr)  m_ovf = 1'b0;
            if (winc && !m_full) m_wr++;
            m_level = m_wr - rd_cnt;
            m_full  = (m_level == 16);
        end
    end

    always @(posedge wclk) begin
        #1;
        if (!rst_n) begin
            prev_wptr = '0;
        end else if (check_en) begin
            check("waddr",        32'(waddr),        32'(m_wr % 16));
            check("wptr",         32'(wptr),         32'(to_gray(m_wr)));
            check("wfull",        32'(wfull),        32'(m_full));
            check("wlevel",       32'(wlevel),       32'(m_level));
            check("wovf",         32'(wovf),         32'(m_ovf));
            check("walmost_full", 32'(walmost_full), 32'(exp_almost(m_level)));
            if (wptr != prev_wptr)
                check("wptr_one_bit", 32'($countones(wptr ^ prev_wptr)), 32'd1);
            prev_wptr = wptr;
        end
    end

    task automatic step(input logic w, input logic clr, input int rd_inc);
        @(negedge wclk);
        winc     = w;
        wovf_clr = clr;
        rd_cnt   = rd_cnt + rd_inc;
        wq2_rptr = to_gray(rd_cnt);
        @(posedge wclk);
        #2;
    endtask

    initial begin
        rst_n    = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Build arbitrary state, then reset asynchronously mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1);
        @(negedge wclk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_waddr",  32'(waddr),        32'd0);
        check("rst_wptr",   32'(wptr),         32'd0);
        check("rst_wfull",  32'(wfull),        32'd0);
        check("rst_wlevel", 32'(wlevel),       32'd0);
        check("rst_wovf",   32'(wovf),         32'd0);
        check("rst_walm",   32'(walmost_full), 32'd0);
        winc     = 1'b0;
        wovf_clr = 1'b0;
        rd_cnt   = 0;
        wq2_rptr = '0;
        @(negedge wclk);
        rst_n = 1'b1;
        winc  = 1'b1;
        #1;
        check("first_waddr_same_cycle", 32'(waddr), 32'd0);
        @(posedge wclk);
        #2;
        check("first_wptr", 32'(wptr), 32'b00001);

        // Fill to full from empty
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 1'b0, 0);
            check("fill_level", 32'(wlevel), 32'(i + 1));
            if (i == 14) check("not_full_at_15", 32'(wfull), 32'd0);
        end
        check("full_flag",  32'(wfull),  32'd1);
        check("full_level", 32'(wlevel), 32'd16);
        check("full_wptr",  32'(wptr),   32'b11000);
        check("full_waddr", 32'(waddr),  32'd0);

        // Writes while full are dropped and set sticky overflow
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("ovf_wptr_hold", 32'(wptr), 32'b11000);
        check("ovf_set",       32'(wovf), 32'd1);
        step(1'b0, 1'b1, 0);
        check("ovf_clear",     32'(wovf), 32'd0);
        step(1'b1, 1'b1, 0);
        check("ovf_set_wins",  32'(wovf), 32'd1);

        // One read frees a slot; next write refills
        step(1'b0, 1'b0, 1);
        check("read_unfull", 32'(wfull),  32'd0);
        check("read_level",  32'(wlevel), 32'd15);
        step(1'b1, 1'b0, 0);
        check("refill_full", 32'(wfull),  32'd1);
        check("refill_wptr", 32'(wptr),   32'b11001);
        step(1'b0, 1'b1, 0);

        // Drain to level 8, then stream write+read across the pointer wrap
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1);
        check("mid_level", 32'(wlevel), 32'd8);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1);
            check("stream_level", 32'(wlevel), 32'd8);
            check("stream_nfull", 32'(wfull),  32'd0);
            if (m_wr % 32 == 31) check("wrap_pre_wptr",  32'(wptr), 32'b10000);
            if (m_wr % 32 == 0)  check("wrap_post_wptr", 32'(wptr), 32'b00000);
        end

        // Drain to empty, then fill and watch almost-full
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1);
        check("empty_level", 32'(wlevel),       32'd0);
        check("empty_alm",   32'(walmost_full), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 0);
`ifdef WPTR_ALMOST_FULL_EN
            check("alm_fill", 32'(walmost_full), (i >= 14) ? 32'd1 : 32'd0);
`else
            check("alm_fill", 32'(walmost_full), 32'd0);
`endif
        end
        check("refull_flag", 32'(wfull), 32'd1);

        step(1'b0, 1'b0, 0);
        repeat (2) @(posedge wclk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
